// File: rtl/cond_pkg.sv
// Shared types and condition-code evaluation for the E-stage conditional unit.
package cond_pkg;

  typedef logic [3:0] flags_t;  // {V,C,N,Z}

  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  localparam int FLAG_V   = 3;
  localparam int FLAG_C   = 2;
  localparam int FLAG_N   = 1;
  localparam int FLAG_Z   = 0;
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

  function automatic logic cond_eval(input cond_e cd, input flags_t f);
    logic v, c, n, z;
    v = f[FLAG_V];
    c = f[FLAG_C];
    n = f[FLAG_N];
    z = f[FLAG_Z];
    case (cd)
      EQ: cond_eval = z;
      NE: cond_eval = ~z;
      CS: cond_eval = c;
      CC: cond_eval = ~c;
      MI: cond_eval = n;
      PL: cond_eval = ~n;
      VS: cond_eval = v;
      VC: cond_eval = ~v;
      HI: cond_eval = ~z & c;
      LS: cond_eval = z | ~c;
      GE: cond_eval = ~(n ^ v);
      LT: cond_eval = n ^ v;
      GT: cond_eval = ~z & ~(n ^ v);
      LE: cond_eval = z | (n ^ v);
      AL: cond_eval = 1'b1;
      default: cond_eval = 1'b0;  // NV: reserved, never fires
    endcase
  endfunction

endpackage

// File: rtl/flag_reg.sv
// Architectural {V,C,N,Z} register with independent NZ / CV write groups.
// FLAG_SHADOW_EN adds an interrupt shadow copy (IrqEntry saves, IrqRet restores).
module flag_reg
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_nz,
  input  logic       we_cv,
  input  logic [3:0] alu_flags,
`ifdef FLAG_SHADOW_EN
  input  logic       irq_entry,
  input  logic       irq_ret,
`endif
  output logic [3:0] flags
);

  flags_t nxt;

`ifdef FLAG_SHADOW_EN
  flags_t shadow;

  // Shadow captures the pre-update flags; with irq_ret in the same cycle this swaps.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)         shadow <= '0;
    else if (irq_entry) shadow <= flags;
`endif

  always_comb begin
    nxt = flags;
    if (we_nz) nxt[FLAG_N:FLAG_Z] = alu_flags[FLAG_N:FLAG_Z];
    if (we_cv) nxt[FLAG_V:FLAG_C] = alu_flags[FLAG_V:FLAG_C];
`ifdef FLAG_SHADOW_EN
    if (irq_ret) nxt = shadow;
`endif
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flags <= '0;
    else        flags <= nxt;

endmodule

// File: rtl/cond_flag_unit.sv
// E-stage condition evaluation, write-enable gating, M-stage enables and squash counter.
// Optional FLAG_SHADOW_EN exposes IrqEntry/IrqRet for interrupt flag save/restore.
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Valid,
  input  logic             Stall,
  input  logic             Flush,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             PCS,
`ifdef FLAG_SHADOW_EN
  input  logic             IrqEntry,
  input  logic             IrqRet,
`endif
  output logic [3:0]       Flags,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [CNT_W-1:0] SquashCnt
);

  logic fire, upd, squash;

  assign CondEx = cond_eval(cond_e'(Cond), Flags);
  assign fire   = Valid & CondEx & ~Flush;
  assign upd    = fire & ~Stall;
  assign squash = Valid & ~CondEx & ~Flush & ~Stall;
  assign PCSrc  = PCS & fire;

  flag_reg u_flag_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_nz     (upd & FlagW[FLAGW_NZ]),
    .we_cv     (upd & FlagW[FLAGW_CV]),
    .alu_flags (ALUFlags),
`ifdef FLAG_SHADOW_EN
    .irq_entry (IrqEntry),
    .irq_ret   (IrqRet),
`endif
    .flags     (Flags)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
    end else if (Flush) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
    end else if (!Stall) begin
      RegWriteM <= RegW & fire;
      MemWriteM <= MemW & fire;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                              SquashCnt <= '0;
    else if (squash && (SquashCnt != '1))   SquashCnt <= SquashCnt + CNT_W'(1);

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench: driver pushes hand-computed expectations, negedge monitor pops and checks.
module tb_cond_flag_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          Valid = 0, Stall = 0, Flush = 0, RegW = 0, MemW = 0, PCS = 0;
  logic [3:0]    Cond = 0, ALUFlags = 0;
  logic [1:0]    FlagW = 0;
  logic          IrqEntry = 0, IrqRet = 0;
  logic [3:0]    Flags;
  logic          CondEx, PCSrc, RegWriteM, MemWriteM;
  logic [CW-1:0] SquashCnt;

  cond_flag_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .Valid(Valid), .Stall(Stall), .Flush(Flush),
    .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .RegW(RegW), .MemW(MemW),
    .PCS(PCS),
`ifdef FLAG_SHADOW_EN
    .IrqEntry(IrqEntry), .IrqRet(IrqRet),
`endif
    .Flags(Flags), .CondEx(CondEx), .PCSrc(PCSrc), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .SquashCnt(SquashCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         nm;
    logic [3:0]    f;
    logic          cex, pc, rm, mm;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
  endtask

  // Inputs applied just after the edge; registered expectations are the state after the previous edge.
  task automatic step(input string nm, input logic rst, v, st, fl, input logic [3:0] cd, alu,
                      input logic [1:0] fw, input logic rw, mw, pcs,
                      input logic [3:0] ef, input logic ecex, epc, erm, emm, input int ecnt,
                      input logic ie = 1'b0, input logic ir = 1'b0);
    exp_t e;
    @(posedge clk); #1;
    rst_n = rst; Valid = v; Stall = st; Flush = fl; Cond = cd; ALUFlags = alu;
    FlagW = fw; RegW = rw; MemW = mw; PCS = pcs; IrqEntry = ie; IrqRet = ir;
    e.nm = nm; e.f = ef; e.cex = ecex; e.pc = epc; e.rm = erm; e.mm = emm; e.cnt = CW'(ecnt);
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "Flags",     32'(Flags),     32'(e.f));
        chk(e.nm, "CondEx",    32'(CondEx),    32'(e.cex));
        chk(e.nm, "PCSrc",     32'(PCSrc),     32'(e.pc));
        chk(e.nm, "RegWriteM", 32'(RegWriteM), 32'(e.rm));
        chk(e.nm, "MemWriteM", 32'(MemWriteM), 32'(e.mm));
        chk(e.nm, "SquashCnt", 32'(SquashCnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    //   name          rst v st fl cond  alu    fw    rw mw pcs   Flags  cex pc rm mm cnt
    step("rst_hold",   0, 1, 0, 0, 4'd1, 4'h0, 2'b00, 1, 0, 0,   4'h0,  1, 0, 0, 0, 0);
    step("eq_fail",    1, 1, 0, 0, 4'd0, 4'h0, 2'b00, 1, 0, 0,   4'h0,  0, 0, 0, 0, 0);
    step("ne_pass",    1, 1, 0, 0, 4'd1, 4'h0, 2'b00, 1, 0, 0,   4'h0,  1, 0, 0, 0, 1);
    step("cmp",        1, 1, 0, 0, 4'd14,4'h5, 2'b11, 0, 0, 0,   4'h0,  1, 0, 1, 0, 1);
    step("beq",        1, 1, 0, 0, 4'd0, 4'h0, 2'b00, 0, 0, 1,   4'h5,  1, 1, 0, 0, 1);
    step("cs_mem",     1, 1, 0, 0, 4'd2, 4'h0, 2'b00, 0, 1, 0,   4'h5,  1, 0, 0, 0, 1);
    step("hi_fail",    1, 1, 0, 0, 4'd8, 4'h0, 2'b00, 1, 0, 0,   4'h5,  0, 0, 0, 1, 1);
    step("fw_nz",      1, 1, 0, 0, 4'd14,4'hE, 2'b10, 0, 0, 0,   4'h5,  1, 0, 0, 0, 2);
    step("fw_cv",      1, 1, 0, 0, 4'd14,4'hD, 2'b01, 0, 0, 0,   4'h6,  1, 0, 0, 0, 2);
    step("set_m",      1, 1, 0, 0, 4'd14,4'h0, 2'b00, 1, 1, 0,   4'hE,  1, 0, 0, 0, 2);
    step("stall",      1, 1, 1, 0, 4'd14,4'h1, 2'b11, 0, 0, 1,   4'hE,  1, 1, 1, 1, 2);
    step("stall_fl",   1, 1, 1, 1, 4'd14,4'h1, 2'b11, 0, 1, 1,   4'hE,  1, 0, 1, 1, 2);
    step("stall_nv",   1, 1, 1, 0, 4'd15,4'h0, 2'b00, 0, 0, 0,   4'hE,  0, 0, 0, 0, 2);
    step("flush_nv",   1, 1, 0, 1, 4'd15,4'h0, 2'b00, 0, 0, 0,   4'hE,  0, 0, 0, 0, 2);
    step("inval_al",   1, 0, 0, 0, 4'd14,4'h0, 2'b11, 1, 1, 1,   4'hE,  1, 0, 0, 0, 2);
    step("inval_nv",   1, 0, 0, 0, 4'd15,4'h0, 2'b00, 0, 0, 0,   4'hE,  0, 0, 0, 0, 2);
    step("lt_fail",    1, 1, 0, 0, 4'd11,4'h0, 2'b00, 0, 0, 0,   4'hE,  0, 0, 0, 0, 2);
    step("gt_pass",    1, 1, 0, 0, 4'd12,4'h0, 2'b00, 0, 0, 0,   4'hE,  1, 0, 0, 0, 3);
    step("ls_fail",    1, 1, 0, 0, 4'd9, 4'h0, 2'b00, 0, 0, 0,   4'hE,  0, 0, 0, 0, 3);
    step("vc_fail",    1, 1, 0, 0, 4'd7, 4'h0, 2'b00, 0, 0, 0,   4'hE,  0, 0, 0, 0, 4);
    for (int k = 0; k < 20; k++)
      step("sat",      1, 1, 0, 0, 4'd15,4'h0, 2'b00, 0, 0, 0,   4'hE,  0, 0, 0, 0, (5 + k > 15) ? 15 : 5 + k);
    step("sat_hold",   1, 1, 0, 0, 4'd15,4'h0, 2'b00, 0, 0, 0,   4'hE,  0, 0, 0, 0, 15);
    step("mid_rst",    0, 1, 0, 0, 4'd0, 4'h0, 2'b00, 1, 0, 0,   4'h0,  0, 0, 0, 0, 0);
    step("post_ne",    1, 1, 0, 0, 4'd1, 4'h0, 2'b00, 1, 0, 0,   4'h0,  1, 0, 0, 0, 0);
    step("le_fail",    1, 1, 0, 0, 4'd13,4'h0, 2'b00, 0, 0, 0,   4'h0,  0, 0, 1, 0, 0);
    step("cc_inval",   1, 0, 0, 0, 4'd3, 4'h0, 2'b00, 0, 0, 0,   4'h0,  1, 0, 0, 0, 1);
    step("vs_inval",   1, 0, 0, 0, 4'd6, 4'h0, 2'b00, 0, 0, 0,   4'h0,  0, 0, 0, 0, 1);
    step("pl_inval",   1, 0, 0, 0, 4'd5, 4'h0, 2'b00, 0, 0, 0,   4'h0,  1, 0, 0, 0, 1);
`ifdef FLAG_SHADOW_EN
    //   name          rst v st fl cond  alu    fw    rw mw pcs   Flags  cex pc rm mm cnt ie ir
    step("sh_set",     1, 1, 0, 0, 4'd14,4'h9, 2'b11, 0, 0, 0,   4'h0,  1, 0, 0, 0, 1);
    step("sh_entry",   1, 0, 0, 0, 4'd14,4'h0, 2'b00, 0, 0, 0,   4'h9,  1, 0, 0, 0, 1, 1, 0);
    step("sh_cmp",     1, 1, 0, 0, 4'd14,4'h4, 2'b11, 0, 0, 0,   4'h9,  1, 0, 0, 0, 1);
    step("sh_ret",     1, 1, 1, 0, 4'd14,4'hF, 2'b11, 0, 0, 0,   4'h4,  1, 0, 0, 0, 1, 0, 1);
    step("sh_cmp2",    1, 1, 0, 0, 4'd14,4'h4, 2'b11, 0, 0, 0,   4'h9,  1, 0, 0, 0, 1);
    step("sh_swap",    1, 0, 0, 0, 4'd14,4'h0, 2'b00, 0, 0, 0,   4'h4,  1, 0, 0, 0, 1, 1, 1);
    step("sh_ret2",    1, 0, 0, 0, 4'd14,4'h0, 2'b00, 0, 0, 0,   4'h9,  1, 0, 0, 0, 1, 0, 1);
    step("sh_ent_upd", 1, 1, 0, 0, 4'd14,4'h3, 2'b11, 0, 0, 0,   4'h4,  1, 0, 0, 0, 1, 1, 0);
    step("sh_ret3",    1, 0, 0, 0, 4'd14,4'h0, 2'b00, 0, 0, 0,   4'h3,  1, 0, 0, 0, 1, 0, 1);
    step("sh_final",   1, 0, 0, 0, 4'd14,4'h0, 2'b00, 0, 0, 0,   4'h4,  1, 0, 0, 0, 1);
`endif
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
